// File: rtl/id_ex_stage.sv
// RV64I decode plus ID/EX pipeline register: operand capture with WB bypass,
// immediate generation, EX control decode and single-bubble load-use stall.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    output logic            id_stall,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_reg_write,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_alu_src,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]      opc;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] imm, op1, op2;
    logic            known, use1, use2, hz;
    logic            d_mem_read, d_mem_write, d_reg_write, d_branch, d_jump, d_alu_src;
    logic            load_en;

    assign opc    = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    always_comb begin
        known       = 1'b1;
        imm         = '0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_alu_src   = 1'b1;
        case (opc)
            OP_LOAD: begin
                imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
                d_mem_read = 1'b1; d_reg_write = 1'b1;
            end
            OP_IMM, OP_IMM32: begin
                imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
                d_reg_write = 1'b1;
            end
            OP_JALR: begin
                imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
                d_reg_write = 1'b1; d_jump = 1'b1;
            end
            OP_STORE: begin
                imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                d_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                imm = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                       if_instr[11:8], 1'b0};
                d_branch = 1'b1; d_alu_src = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
                d_reg_write = 1'b1;
            end
            OP_JAL: begin
                imm = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20],
                       if_instr[30:21], 1'b0};
                d_reg_write = 1'b1; d_jump = 1'b1;
            end
            OP_OP, OP_OP32: begin
                d_reg_write = 1'b1; d_alu_src = 1'b0;
            end
            default: begin
                known = 1'b0; d_alu_src = 1'b0;
            end
        endcase
        if (rd == '0) d_reg_write = 1'b0;
    end

    assign use1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign use2 = (opc == OP_OP || opc == OP_OP32 || opc == OP_STORE || opc == OP_BRANCH);

    // The register file commits WB data at the same edge, so its read port is stale here.
    always_comb begin
        op1 = rf_rdata1;
        if (rs1 == '0) op1 = '0;
        else if (wb_reg_write && wb_rd == rs1) op1 = wb_data;
        op2 = rf_rdata2;
        if (rs2 == '0) op2 = '0;
        else if (wb_reg_write && wb_rd == rs2) op2 = wb_data;
    end

    assign hz = if_valid && ex_valid && ex_mem_read && ex_rd != '0 &&
                ((use1 && ex_rd == rs1) || (use2 && ex_rd == rs2));
    assign id_stall = !reset && !ex_flush && hz;
    assign load_en  = if_valid && !ex_flush && !hz;

    always_ff @(posedge clk) begin
        if (reset || !load_en) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_imm       <= imm;
            ex_rs1_data  <= op1;
            ex_rs2_data  <= op2;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_rd        <= rd;
            ex_opcode    <= opc;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_mem_read  <= d_mem_read;
            ex_mem_write <= d_mem_write;
            ex_reg_write <= d_reg_write;
            ex_branch    <= d_branch;
            ex_jump      <= d_jump;
            ex_alu_src   <= d_alu_src;
            ex_illegal   <= !known;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: decode, bypass, load-use stall, flush, reset.
module tb_id_ex_stage;
    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            id_stall;
    logic [AW-1:0]   rf_rs1, rf_rs2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            wb_reg_write;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [AW-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_alu_src, ex_illegal;

    int passed = 0;
    int total  = 0;

    // {mem_read, mem_write, reg_write, branch, jump, alu_src, illegal}
    logic [6:0] ctrl;
    assign ctrl = {ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_alu_src, ex_illegal};

    localparam logic [31:0] ADDI  = 32'h00700293;  // addi x5,x0,7
    localparam logic [31:0] BEQ   = 32'hFE000EE3;  // beq x0,x0,-4
    localparam logic [31:0] LD    = 32'h0002B303;  // ld x6,0(x5)
    localparam logic [31:0] ADD   = 32'h005303B3;  // add x7,x6,x5
    localparam logic [31:0] SUB   = 32'h405303B3;  // sub x7,x6,x5
    localparam logic [31:0] ADDX0 = 32'h000283B3;  // add x7,x5,x0
    localparam logic [31:0] JAL   = 32'h008000EF;  // jal x1,8
    localparam logic [31:0] LUI   = 32'h800001B7;  // lui x3,0x80000
    localparam logic [31:0] BAD   = 32'h0000007F;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .id_stall(id_stall), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src), .ex_illegal(ex_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        rf_rdata1 = 64'h1234; rf_rdata2 = 64'h5678;
        issue(ADDI, 64'h40);
        step(); step();
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ex_valid); else passed++;
        total++; if (ctrl !== 7'b0) $display("FAIL reset_ctrl got %b want 0", ctrl); else passed++;
        total++; if ({ex_pc, ex_imm, ex_rd} !== '0) $display("FAIL reset_fields pc=%h imm=%h rd=%0d want 0", ex_pc, ex_imm, ex_rd); else passed++;
        total++; if (id_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", id_stall); else passed++;
        reset = 1'b0;
        issue(ADDI, 64'h0);
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", ex_valid); else passed++;
        total++; if (ex_rd !== 5'd5) $display("FAIL addi_rd got %0d want 5", ex_rd); else passed++;
        total++; if (ex_imm !== 64'd7) $display("FAIL addi_imm got %h want 7", ex_imm); else passed++;
        total++; if (ctrl !== 7'b0010010) $display("FAIL addi_ctrl got %b want 0010010", ctrl); else passed++;
    endtask

    task automatic test_decode();
        issue(BEQ, 64'h100);
        step();
        total++; if (ex_imm !== 64'hFFFFFFFFFFFFFFFC) $display("FAIL beq_imm got %h want fffffffffffffffc", ex_imm); else passed++;
        total++; if (ctrl !== 7'b0001000) $display("FAIL beq_ctrl got %b want 0001000", ctrl); else passed++;
        total++; if (ex_pc !== 64'h100) $display("FAIL beq_pc got %h want 100", ex_pc); else passed++;
        issue(JAL, 64'h200);
        step();
        total++; if (ex_imm !== 64'd8) $display("FAIL jal_imm got %h want 8", ex_imm); else passed++;
        total++; if (ctrl !== 7'b0010110) $display("FAIL jal_ctrl got %b want 0010110", ctrl); else passed++;
        issue(LUI, 64'h204);
        step();
        total++; if (ex_imm !== 64'hFFFFFFFF80000000) $display("FAIL lui_imm got %h want ffffffff80000000", ex_imm); else passed++;
        total++; if (ex_rd !== 5'd3) $display("FAIL lui_rd got %0d want 3", ex_rd); else passed++;
        issue(SUB, 64'h208);
        step();
        total++; if ({ex_funct7b5, ex_funct3, ex_opcode} !== {1'b1, 3'b000, 7'b0110011}) $display("FAIL sub_fields got %b/%b/%b want 1/000/0110011", ex_funct7b5, ex_funct3, ex_opcode); else passed++;
        total++; if (ctrl !== 7'b0010000) $display("FAIL sub_ctrl got %b want 0010000", ctrl); else passed++;
    endtask

    task automatic test_load_use();
        rf_rdata1 = 64'h1000; rf_rdata2 = 64'h0;
        issue(LD, 64'h300);
        total++; if (id_stall !== 1'b0) $display("FAIL ld_nostall got %b want 0", id_stall); else passed++;
        step();
        total++; if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd6}) $display("FAIL ld_ex got v=%b mr=%b rd=%0d want 1/1/6", ex_valid, ex_mem_read, ex_rd); else passed++;
        total++; if (ex_rs1_data !== 64'h1000) $display("FAIL ld_op1 got %h want 1000", ex_rs1_data); else passed++;
        rf_rdata1 = 64'h11; rf_rdata2 = 64'h22;
        issue(ADD, 64'h304);
        total++; if (id_stall !== 1'b1) $display("FAIL lu_stall got %b want 1", id_stall); else passed++;
        step();
        total++; if ({ex_valid, ctrl} !== 8'b0) $display("FAIL lu_bubble got v=%b ctrl=%b want 0", ex_valid, ctrl); else passed++;
        total++; if (id_stall !== 1'b0) $display("FAIL lu_stall_one got %b want 0", id_stall); else passed++;
        step();
        total++; if ({ex_valid, ex_rd, ex_rs1, ex_rs2} !== {1'b1, 5'd7, 5'd6, 5'd5}) $display("FAIL lu_add got v=%b rd=%0d rs1=%0d rs2=%0d want 1/7/6/5", ex_valid, ex_rd, ex_rs1, ex_rs2); else passed++;
        total++; if ({ex_rs1_data, ex_rs2_data} !== {64'h11, 64'h22}) $display("FAIL lu_ops got %h/%h want 11/22", ex_rs1_data, ex_rs2_data); else passed++;
        total++; if (ctrl !== 7'b0010000) $display("FAIL lu_add_ctrl got %b want 0010000", ctrl); else passed++;
    endtask

    task automatic test_bypass();
        rf_rdata1 = 64'h0; rf_rdata2 = 64'h55;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 64'h2A;
        issue(ADDX0, 64'h400);
        step();
        total++; if (ex_rs1_data !== 64'h2A) $display("FAIL byp_rs1 got %h want 2a", ex_rs1_data); else passed++;
        total++; if (ex_rs2_data !== 64'h0) $display("FAIL byp_x0_rs2 got %h want 0", ex_rs2_data); else passed++;
        wb_rd = 5'd0; rf_rdata1 = 64'h99;
        issue(ADDI, 64'h404);
        step();
        total++; if (ex_rs1_data !== 64'h0) $display("FAIL byp_x0 got %h want 0", ex_rs1_data); else passed++;
        wb_reg_write = 1'b0; wb_rd = 5'd5; rf_rdata1 = 64'h77;
        issue(ADDX0, 64'h408);
        step();
        total++; if (ex_rs1_data !== 64'h77) $display("FAIL byp_off got %h want 77", ex_rs1_data); else passed++;
    endtask

    task automatic test_flush();
        issue(LD, 64'h500);
        step();
        issue(ADD, 64'h504);
        ex_flush = 1'b1;
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL flush_stall got %b want 0", id_stall); else passed++;
        step();
        total++; if ({ex_valid, ctrl} !== 8'b0) $display("FAIL flush_bubble got v=%b ctrl=%b want 0", ex_valid, ctrl); else passed++;
        ex_flush = 1'b0;
        issue(ADD, 64'h600);
        total++; if (id_stall !== 1'b0) $display("FAIL flush_next_stall got %b want 0", id_stall); else passed++;
        step();
        total++; if ({ex_valid, ex_pc} !== {1'b1, 64'h600}) $display("FAIL flush_next got v=%b pc=%h want 1/600", ex_valid, ex_pc); else passed++;
        if_valid = 1'b0;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL invalid_bubble got %b want 0", ex_valid); else passed++;
    endtask

    task automatic test_illegal_reset();
        issue(BAD, 64'h700);
        step();
        total++; if ({ex_valid, ex_illegal} !== 2'b11) $display("FAIL ill_flags got v=%b ill=%b want 1/1", ex_valid, ex_illegal); else passed++;
        total++; if (ctrl !== 7'b0000001) $display("FAIL ill_ctrl got %b want 0000001", ctrl); else passed++;
        total++; if (ex_imm !== 64'h0) $display("FAIL ill_imm got %h want 0", ex_imm); else passed++;
        issue(LD, 64'h704);
        step();
        reset = 1'b1;
        issue(ADD, 64'h708);
        total++; if (id_stall !== 1'b0) $display("FAIL rst_hz_stall got %b want 0", id_stall); else passed++;
        step();
        total++; if ({ex_valid, ctrl, ex_pc} !== '0) $display("FAIL rst_mid got v=%b ctrl=%b pc=%h want 0", ex_valid, ctrl, ex_pc); else passed++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_bypass();
        test_flush();
        test_illegal_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
